// File: rtl/irq_sched_if.sv
// Handshake bundle between the interrupt scheduler and the pipeline.
// The scheduler is the slave side. The pipeline, or a bench standing in for it, is the master side.
interface irq_sched_if #(
  parameter int unsigned NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq_in;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic               stall;
  logic               irq_ack;
  logic               reti;
  logic               irq_req;
  logic [7:0]         irq_vec;
  logic [2:0]         irq_id;
  logic               busy;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;

  modport master (
    output irq_in, mask_we, mask_wdata, stall, irq_ack, reti,
    input  irq_req, irq_vec, irq_id, busy, pending, mask
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, stall, irq_ack, reti,
    output irq_req, irq_vec, irq_id, busy, pending, mask
  );
endinterface

// File: rtl/irq_sched_ctrl.sv
// Interrupt scheduler. It edge-detects the interrupt lines and applies the mask and fixed priority (lowest index wins).
// It issues one vector at a time and allows no nesting until reti.
module irq_sched_ctrl #(
  parameter int unsigned NUM_IRQ    = 4,
  parameter logic [7:0]  VEC_BASE   = 8'hF0,
  parameter int unsigned VEC_STRIDE = 4
) (
  input  logic        clk,
  input  logic        reset,
  irq_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] prev_irq;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic               irq_req_q;
  logic [7:0]         irq_vec_q;
  logic [2:0]         irq_id_q;
  logic               busy_q;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [2:0]         winner;
  logic [7:0]         grant_vec;
  logic               ack_take;

  assign rise      = bus.irq_in & ~prev_irq;
  assign eligible  = pending_q & mask_q;
  assign ack_take  = (state == REQ) && bus.irq_ack;
  assign grant_vec = VEC_BASE + 8'(32'(winner) * VEC_STRIDE);

  // NOTE: every signal in an always_comb gets a default value first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    winner = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      ack_clr[i] = ack_take && (irq_id_q == 3'(i));
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples the values from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prev_irq  <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      irq_req_q <= 1'b0;
      irq_vec_q <= '0;
      irq_id_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      prev_irq <= bus.irq_in;
      // A new edge on the line being acknowledged overrides the clear.
      pending_q <= (pending_q & ~ack_clr) | rise;
      if (bus.mask_we) mask_q <= bus.mask_wdata;

      case (state)
        IDLE: begin
          if ((|eligible) && !bus.stall) begin
            state     <= REQ;
            irq_id_q  <= winner;
            irq_vec_q <= grant_vec;
            irq_req_q <= 1'b1;
          end
        end
        REQ: begin
          if (bus.irq_ack) begin
            state     <= SERVICE;
            irq_req_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        SERVICE: begin
          if (bus.reti) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.irq_req = irq_req_q;
  assign bus.irq_vec = irq_vec_q;
  assign bus.irq_id  = irq_id_q;
  assign bus.busy    = busy_q;
  assign bus.pending = pending_q;
  assign bus.mask    = mask_q;

endmodule

// File: doc/irq_sched_ctrl.md
Name: irq_sched_ctrl

Overview:
Interrupt scheduler for the 8-bit pipelined processor. It sits between the external interrupt lines and the jump-control stage. It edge-detects and latches up to NUM_IRQ requests, applies a software mask and fixed priority, and presents one vector at a time to jump control. It tracks the in-service interrupt until the pipeline signals return-from-interrupt, and does not allow nesting.

Parameters:
NUM_IRQ, 4, number of interrupt lines (2..8); irq_id width is 3 bits regardless.
VEC_BASE, 8'hF0, instruction-memory address of the vector for irq 0.
VEC_STRIDE, 4, address spacing between consecutive vectors.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
irq_in  input  NUM_IRQ  interrupt lines, synchronous to clk, level-high; rising edge = request.
mask_we  input  1  write strobe for mask register.
mask_wdata  input  NUM_IRQ  new mask value; 1 = enabled.
stall  input  1  pipeline stall; no new grant is issued while high.
irq_ack  input  1  jump control has loaded irq_vec into the PC; one-cycle pulse.
reti  input  1  return-from-interrupt retired; one-cycle pulse.
irq_req  output  1  vector request to jump control (registered).
irq_vec  output  8  vector address, valid while irq_req=1 (registered).
irq_id  output  3  granted line index (registered).
busy  output  1  interrupt in service (registered).
pending  output  NUM_IRQ  latched pending bits (registered), unmasked view.
mask  output  NUM_IRQ  current mask register.

Behaviour:
- Reset (async, any state): prev_irq=0, pending=0, mask=all ones, irq_req=0, irq_vec=0, irq_id=0, busy=0, FSM=IDLE. Reset mid-request or mid-service discards everything, including in-flight pending bits.
- Edge detect: at each clk edge prev_irq<=irq_in. Bit i is set in pending at edge k if irq_in[i]=1 and prev_irq[i]=0 at edge k. A held-high line sets pending only once.
- Masking: masked lines still latch pending but are not eligible. mask_we writes at the clock edge. The new mask affects eligibility from the next cycle and does not retract a request already issued.
- Eligible = pending & mask. Priority: lowest index wins.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if eligible!=0 and stall=0 at an edge, go to REQ. At the same edge, latch irq_id=winner, irq_vec=VEC_BASE+winner*VEC_STRIDE (8-bit, wraps mod 256), irq_req<=1.
  - REQ: irq_req, irq_vec and irq_id are held stable regardless of stall or new higher-priority edges. On irq_ack: irq_req<=0, busy<=1, pending[irq_id]<=0, go to SERVICE.
  - SERVICE: no new grants. On reti: busy<=0, go to IDLE. The next grant can occur at the following edge, giving one cycle of IDLE minimum.
- Latency: edge sampled at clock k sets pending at k. irq_req rises at k+1 if the FSM is in IDLE, stall=0 and the line is unmasked.
- Simultaneous events:
  - New edge on the same line as an irq_ack clear: set wins; the bit stays pending.
  - mask_we together with a grant decision: the grant uses the old mask.
  - irq_ack outside REQ is ignored.
  - reti outside SERVICE is ignored.
  - irq_ack and reti in the same cycle: only the ack takes effect when in REQ.
- pending is never cleared by masking; only ack or reset clear it.

Test Plan:
1. Reset asserted mid-SERVICE with pending=4'b0110 -> all outputs 0 immediately (async), mask=4'hF; after release, no irq_req until a fresh edge.
2. Single edge on irq_in[2] at edge k, stall=0 -> pending=4'b0100 at k, irq_req=1 with irq_vec=8'hF8 and irq_id=2 at k+1. Ack -> busy=1 and pending=0. Reti -> busy=0.
3. Simultaneous edges on lines 1 and 3 -> first grant id=1, vec=8'hF4. After ack+reti, second grant id=3, vec=8'hFC with no edge needed.
4. Edge on line 0 while stall=1 for 5 cycles -> no irq_req during stall; irq_req rises the cycle after stall falls. Stall raised during REQ -> irq_req held, vec unchanged.
5. mask=4'b1110, edge on line 0 -> pending[0]=1, no request. Write mask=4'hF -> request for id 0 follows one cycle later. Edge on line 0 in the same cycle as its ack -> pending[0] remains 1 and is re-granted after reti.
6. VEC_BASE=8'hFC, VEC_STRIDE=4, edge on line 1 -> irq_vec=8'h00 (wrap). A held-high irq_in[1] generates no second request after service.
